ahb_decoder_mux: RTL and testbench

- Parametrised AHB-Lite address decoder plus read-response multiplexer for one master-side bus segment feeding SLV_NUM slaves.
- Generates address-phase hsel from a configurable region field.
- Registers the data-phase selection, so response, ready and read data come from the slave that owns the current data phase, not the address now on the bus.
- Holds a built-in default slave that returns the two-cycle AHB ERROR response for active transfers to unmapped addresses, and counts decode errors.

---
 rtl/ahb_pkg.sv | 16 +
 rtl/ahb_default_slave.sv | 58 +++++
 rtl/ahb_decoder_mux.sv | 82 ++++++++
 tb/tb_ahb_decoder_mux.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and the default-slave state type shared by the decoder/mux.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

  function automatic logic trans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction
endpackage

// File: rtl/ahb_default_slave.sv
// Built-in slave for unmapped addresses: two-cycle ERROR response plus error counting.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             hready,
  input  logic             sel,
  input  logic             dp_map,
  output logic             ds_hready,
  output logic             ds_hresp,
  output logic             dec_err,
  output logic [CNT_W-1:0] err_cnt
);
  ds_state_e state;
  logic      rdy_q, resp_q, accept;

  assign accept = hready && sel;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= DS_IDLE;
      rdy_q   <= 1'b1;
      resp_q  <= HRESP_OKAY;
      dec_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      dec_err <= 1'b0;
      case (state)
        DS_ERR1: begin
          state  <= DS_ERR2;
          rdy_q  <= 1'b1;
          resp_q <= HRESP_ERROR;
        end
        default: begin
          // IDLE and ERR2 share the accept test; ERR2 -> ERR1 gives back-to-back errors
          if (accept) begin
            state   <= DS_ERR1;
            rdy_q   <= 1'b0;
            resp_q  <= HRESP_ERROR;
            dec_err <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end else begin
            state  <= DS_IDLE;
            rdy_q  <= 1'b1;
            resp_q <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Neutral contribution whenever a real slave owns the data phase.
  assign ds_hready = rdy_q | dp_map;
  assign ds_hresp  = resp_q & ~dp_map;
endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and data-phase response mux with a built-in default slave.
module ahb_decoder_mux
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int SLV_NUM    = 4,
  parameter int SEL_LSB    = 10,
  parameter int SEL_W      = 2,
  parameter int MAP_TAG    = 0,
  parameter int CNT_W      = 8
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  output logic                  hready_o,
  output logic                  hresp_o,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  input  logic [SLV_NUM-1:0]    hready_i,
  input  logic [SLV_NUM-1:0]    hresp_i,
  input  logic [DATA_WIDTH-1:0] hrdata_i [0:SLV_NUM-1],
  output logic [SLV_NUM-1:0]    hsel,
  output logic                  dec_err,
  output logic [CNT_W-1:0]      err_cnt
);
  localparam int TAG_LSB = SEL_LSB + SEL_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

  if (SLV_NUM > (1 << SEL_W)) begin : g_bad_slv_num
    $error("ahb_decoder_mux: SLV_NUM exceeds 2**SEL_W");
  end

  logic [SEL_W-1:0] idx, dp_slv;
  logic             mapped, dp_map;
  logic             ds_hready, ds_hresp;
  logic             unused_lo;

  assign unused_lo = ^haddr[SEL_LSB-1:0];
  assign idx       = haddr[SEL_LSB +: SEL_W];
  assign mapped    = (haddr[ADDR_WIDTH-1:TAG_LSB] == TAG_W'(MAP_TAG)) && (32'(idx) < SLV_NUM);

  always_comb begin
    hsel = '0;
    if (mapped) hsel[idx] = 1'b1;
  end

  // Data-phase owner advances only when the bus accepts the address phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_slv <= '0;
      dp_map <= 1'b0;
    end else if (hready_o) begin
      dp_slv <= idx;
      dp_map <= mapped;
    end
  end

  always_comb begin
    if (dp_map) begin
      hready_o = hready_i[dp_slv];
      hresp_o  = hresp_i[dp_slv];
      hrdata_o = hrdata_i[dp_slv];
    end else begin
      hready_o = ds_hready;
      hresp_o  = ds_hresp;
      hrdata_o = '0;
    end
  end

  ahb_default_slave #(.CNT_W(CNT_W)) u_dflt (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hready   (hready_o),
    .sel      (!mapped && trans_active(htrans)),
    .dp_map   (dp_map),
    .ds_hready(ds_hready),
    .ds_hresp (ds_hresp),
    .dec_err  (dec_err),
    .err_cnt  (err_cnt)
  );
endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Scoreboard bench: stimulus queues expected data-phase responses, a monitor pops them.
module tb_ahb_decoder_mux;
  import ahb_pkg::*;

  logic        hclk, hresetn;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hready_o, hresp_o;
  logic [31:0] hrdata_o;
  logic [3:0]  hready_i, hresp_i;
  logic [31:0] hrdata_i [0:3];
  logic [3:0]  hsel;
  logic        dec_err;
  logic [1:0]  err_cnt;

  ahb_decoder_mux #(.CNT_W(2)) dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hready_o(hready_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o),
    .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i),
    .hsel(hsel), .dec_err(dec_err), .err_cnt(err_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct { logic resp; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int   n_vec = 0, n_bad = 0;
  logic [1:0] exp_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic r, input logic [31:0] d);
    exp_t e;
    e.resp = r;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge hclk);
    while (!hready_o && n < 20) begin
      @(negedge hclk);
      n++;
    end
    if (!hready_o) chk("ready_timeout", 64'(hready_o), 64'd1);
  endtask

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  // Monitor: a data phase completes on any cycle with hready_o high.
  initial begin
    logic in_dp;
    exp_t e;
    in_dp = 1'b0;
    forever begin
      @(negedge hclk);
      if (!hresetn) in_dp = 1'b0;
      else if (hready_o) begin
        if (in_dp) begin
          if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("dp_resp", 64'(hresp_o), 64'(e.resp));
            chk("dp_rdata", 64'(hrdata_o), 64'(e.data));
          end
        end
        in_dp = htrans[1];
      end
    end
  end

  initial begin
    hresetn = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
    hready_i = '1; hresp_i = '0;
    hrdata_i[0] = 32'h0000_A000; hrdata_i[1] = 32'h1111_B001;
    hrdata_i[2] = 32'h2222_C002; hrdata_i[3] = 32'h3333_D003;
    exp_cnt = 2'd0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hready", 64'(hready_o), 64'd1);
    chk("rst_hresp", 64'(hresp_o), 64'd0);
    chk("rst_hrdata", 64'(hrdata_o), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_dec_err", 64'(dec_err), 64'd0);
    #2 hresetn = 1'b1;
    next_cycle();
    haddr = 16'h0800;
    #1 chk("hsel_slv2", 64'(hsel), 64'b0100);

    // Read to slave3 with two wait states
    next_cycle();
    hready_i[3] = 1'b0; hrdata_i[3] = 32'hBAD0_0003;
    haddr = 16'h0C00; htrans = HTRANS_NONSEQ; push(HRESP_OKAY, 32'hDEADBEEF);
    #1 chk("hsel_slv3", 64'(hsel), 64'b1000);
    wait_ready();
    next_cycle();
    haddr = 16'h0000; htrans = HTRANS_NONSEQ; push(HRESP_OKAY, 32'h0000_A000);
    @(negedge hclk) chk("wait1_hready", 64'(hready_o), 64'd0);
    next_cycle();
    @(negedge hclk);
    chk("wait2_hready", 64'(hready_o), 64'd0);
    chk("mux_hold", 64'(hrdata_o), 64'h0BAD0_0003);
    next_cycle();
    hready_i[3] = 1'b1; hrdata_i[3] = 32'hDEADBEEF;
    @(negedge hclk) chk("rd_hready", 64'(hready_o), 64'd1);
    next_cycle();
    // Slave1 error response passes through the mux
    hresp_i[1] = 1'b1;
    haddr = 16'h0400; htrans = HTRANS_NONSEQ; push(HRESP_ERROR, 32'h1111_B001);
    next_cycle();
    htrans = HTRANS_IDLE;
    next_cycle();
    hresp_i[1] = 1'b0;

    // Single unmapped error
    haddr = 16'h4000; htrans = HTRANS_NONSEQ; push(HRESP_ERROR, 32'h0);
    #1 chk("hsel_unmapped", 64'(hsel), 64'd0);
    wait_ready();
    next_cycle();
    haddr = 16'h0000; htrans = HTRANS_IDLE; exp_cnt = sat_inc(exp_cnt);
    @(negedge hclk);
    chk("err1_hready", 64'(hready_o), 64'd0);
    chk("err1_hresp", 64'(hresp_o), 64'd1);
    chk("err1_dec_err", 64'(dec_err), 64'd1);
    next_cycle();
    @(negedge hclk);
    chk("err2_hready", 64'(hready_o), 64'd1);
    chk("err2_hresp", 64'(hresp_o), 64'd1);
    chk("err2_dec_err", 64'(dec_err), 64'd0);
    chk("err_cnt_1", 64'(err_cnt), 64'(exp_cnt));

    // IDLE to an unmapped address is a zero-wait OKAY
    next_cycle();
    haddr = 16'h1000; htrans = HTRANS_IDLE;
    #1 chk("hsel_idle_unmapped", 64'(hsel), 64'd0);
    next_cycle();
    @(negedge hclk);
    chk("idle_hready", 64'(hready_o), 64'd1);
    chk("idle_hresp", 64'(hresp_o), 64'd0);
    chk("idle_dec_err", 64'(dec_err), 64'd0);
    chk("idle_err_cnt", 64'(err_cnt), 64'(exp_cnt));

    // Back-to-back errors: ERR1, ERR2, ERR1, ERR2
    next_cycle();
    haddr = 16'h4000; htrans = HTRANS_NONSEQ; push(HRESP_ERROR, 32'h0);
    next_cycle();
    haddr = 16'h4004; htrans = HTRANS_SEQ; push(HRESP_ERROR, 32'h0); exp_cnt = sat_inc(exp_cnt);
    @(negedge hclk);
    chk("b2b_e1a_hready", 64'(hready_o), 64'd0);
    chk("b2b_e1a_dec_err", 64'(dec_err), 64'd1);
    next_cycle();
    @(negedge hclk);
    chk("b2b_e2a_hready", 64'(hready_o), 64'd1);
    chk("b2b_e2a_hresp", 64'(hresp_o), 64'd1);
    next_cycle();
    haddr = 16'h0000; htrans = HTRANS_IDLE; exp_cnt = sat_inc(exp_cnt);
    @(negedge hclk);
    chk("b2b_e1b_hready", 64'(hready_o), 64'd0);
    chk("b2b_e1b_hresp", 64'(hresp_o), 64'd1);
    chk("b2b_e1b_dec_err", 64'(dec_err), 64'd1);
    next_cycle();
    @(negedge hclk);
    chk("b2b_e2b_hready", 64'(hready_o), 64'd1);
    chk("b2b_err_cnt", 64'(err_cnt), 64'(exp_cnt));

    // Two more errors: five in total must hold at 3, not wrap
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      haddr = 16'h4000; htrans = HTRANS_NONSEQ; push(HRESP_ERROR, 32'h0);
      next_cycle();
      htrans = HTRANS_IDLE; exp_cnt = sat_inc(exp_cnt);
      next_cycle();
      @(negedge hclk) chk("sat_err_cnt", 64'(err_cnt), 64'(exp_cnt));
    end
    chk("sat_value", 64'(err_cnt), 64'd3);

    // Reset pulse during ERR1
    next_cycle();
    haddr = 16'h4000; htrans = HTRANS_NONSEQ; push(HRESP_ERROR, 32'h0);
    next_cycle();
    haddr = 16'h0000; htrans = HTRANS_IDLE;
    @(negedge hclk) chk("mid_dec_err", 64'(dec_err), 64'd1);
    #1 hresetn = 1'b0;
    sb.delete(); exp_cnt = 2'd0;
    #1;
    chk("mid_rst_hready", 64'(hready_o), 64'd1);
    chk("mid_rst_hresp", 64'(hresp_o), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    @(negedge hclk);
    #2 hresetn = 1'b1;
    next_cycle();
    haddr = 16'h0000; htrans = HTRANS_NONSEQ; push(HRESP_OKAY, 32'h0000_A000);
    wait_ready();
    next_cycle();
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    chk("post_rst_hresp", 64'(hresp_o), 64'd0);
    chk("post_rst_dec_err", 64'(dec_err), 64'd0);
    next_cycle();
    next_cycle();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
